// File: rtl/boreal_gate_enforcer.sv
// boreal_gate_enforcer
// Enforcement stage of the Boreal Gate. Accepts commit requests over a
// valid/ready handshake, checks each one against the live policy inputs
// (nonce, target allowlist, rate limit) and returns a grant/deny verdict.
// It also owns the monotonic commit nonce and the saturating denial counter.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   allow0 / allow1       allowlist bits, targets 0-31 / 32-63
//   rate_limit            max grants per window
//   rate_window           window length in cycles (0 behaves as 1)
//   policy_hash           active policy hash, snapshotted into resp_hash
//   override_reg          bit0 bypasses the allowlist, bit1 bypasses the rate limit
//   override_lock         forces the override to 0 when set
//   req_valid/req_ready   request handshake; req_target, req_nonce payload
//   resp_valid/resp_ready verdict handshake; resp_grant, resp_reason, resp_hash
//   nonce_val             current expected nonce
//   deny_cnt              saturating denial count
//   dbg_state             FSM state (0 IDLE, 1 CHECK, 2 RESP)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. req_ready and resp_valid come from the state register only, so
// they never depend combinationally on req_valid or resp_ready. While
// resp_valid is 1, every resp_* output holds its value until the transfer.
module boreal_gate_enforcer #(
  parameter int TGT_W      = 6,
  parameter int DENY_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           allow0,
  input  logic [31:0]           allow1,
  input  logic [31:0]           rate_limit,
  input  logic [31:0]           rate_window,
  input  logic [31:0]           policy_hash,
  input  logic [31:0]           override_reg,
  input  logic                  override_lock,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [TGT_W-1:0]      req_target,
  input  logic [31:0]           req_nonce,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_grant,
  output logic [1:0]            resp_reason,
  output logic [31:0]           resp_hash,
  output logic [31:0]           nonce_val,
  output logic [DENY_CNT_W-1:0] deny_cnt,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic [1:0] RSN_GRANT  = 2'd0;
  localparam logic [1:0] RSN_NONCE  = 2'd1;
  localparam logic [1:0] RSN_TARGET = 2'd2;
  localparam logic [1:0] RSN_RATE   = 2'd3;

  state_t                state_q;
  logic [TGT_W-1:0]      tgt_q;
  logic [31:0]           req_nonce_q;
  logic [31:0]           nonce_q, nonce_d;
  logic [31:0]           win_cnt_q, win_cnt_d;
  logic [31:0]           commit_cnt_q, commit_cnt_d;
  logic [DENY_CNT_W-1:0] deny_cnt_q, deny_cnt_d;
  logic                  resp_grant_q;
  logic [1:0]            resp_reason_q;
  logic [31:0]           resp_hash_q;

  logic [1:0]  eff_ovr;
  logic [63:0] allow_all;
  logic        allow_bit;
  logic [1:0]  reason_d;
  logic        grant_now;
  logic        deny_now;
  logic [31:0] win_last;
  logic        rollover;

  // Only the two low override bits carry meaning.
  logic unused_ovr;
  assign unused_ovr = ^override_reg[31:2];

  always_comb begin
    eff_ovr   = override_lock ? 2'b00 : override_reg[1:0];
    allow_all = {allow1, allow0};
    // Targets beyond the 64-entry allowlist are never allowed.
    allow_bit = (int'(tgt_q) < 64) ? allow_all[6'(tgt_q)] : 1'b0;

    // Priority order: nonce, then target, then rate. The nonce check has
    // no bypass.
    if (req_nonce_q != nonce_q) begin
      reason_d = RSN_NONCE;
    end else if (!allow_bit && !eff_ovr[0]) begin
      reason_d = RSN_TARGET;
    end else if ((commit_cnt_q >= rate_limit) && !eff_ovr[1]) begin
      reason_d = RSN_RATE;
    end else begin
      reason_d = RSN_GRANT;
    end

    grant_now = (state_q == ST_CHECK) && (reason_d == RSN_GRANT);
    deny_now  = (state_q == ST_CHECK) && (reason_d != RSN_GRANT);

    // A zero window is treated as a one-cycle window.
    win_last  = (rate_window == 32'd0) ? 32'd0 : (rate_window - 32'd1);
    rollover  = (win_cnt_q >= win_last);
    win_cnt_d = rollover ? 32'd0 : (win_cnt_q + 32'd1);

    // A grant on the rollover edge is the first commit of the new window.
    if (rollover) begin
      commit_cnt_d = grant_now ? 32'd1 : 32'd0;
    end else if (grant_now && (commit_cnt_q != 32'hFFFF_FFFF)) begin
      commit_cnt_d = commit_cnt_q + 32'd1;
    end else begin
      commit_cnt_d = commit_cnt_q;
    end

    nonce_d = grant_now ? (nonce_q + 32'd1) : nonce_q;

    if (deny_now && (deny_cnt_q != {DENY_CNT_W{1'b1}})) begin
      deny_cnt_d = deny_cnt_q + DENY_CNT_W'(1);
    end else begin
      deny_cnt_d = deny_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      tgt_q         <= '0;
      req_nonce_q   <= 32'd0;
      nonce_q       <= 32'd0;
      win_cnt_q     <= 32'd0;
      commit_cnt_q  <= 32'd0;
      deny_cnt_q    <= '0;
      resp_grant_q  <= 1'b0;
      resp_reason_q <= RSN_GRANT;
      resp_hash_q   <= 32'd0;
    end else begin
      win_cnt_q    <= win_cnt_d;
      commit_cnt_q <= commit_cnt_d;
      nonce_q      <= nonce_d;
      deny_cnt_q   <= deny_cnt_d;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            tgt_q       <= req_target;
            req_nonce_q <= req_nonce;
            state_q     <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          resp_grant_q  <= (reason_d == RSN_GRANT);
          resp_reason_q <= reason_d;
          resp_hash_q   <= policy_hash;
          state_q       <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign resp_valid  = (state_q == ST_RESP);
  assign resp_grant  = resp_grant_q;
  assign resp_reason = resp_reason_q;
  assign resp_hash   = resp_hash_q;
  assign nonce_val   = nonce_q;
  assign deny_cnt    = deny_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_boreal_gate_enforcer.sv
// Directed testbench for boreal_gate_enforcer. Each scenario task drives
// requests and compares the verdict and counters with hand-computed values.
module tb_boreal_gate_enforcer;

  localparam int TGT_W      = 6;
  localparam int DENY_CNT_W = 16;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [31:0]           allow0, allow1, rate_limit, rate_window, policy_hash, override_reg;
  logic                  override_lock;
  logic                  req_valid, req_ready;
  logic [TGT_W-1:0]      req_target;
  logic [31:0]           req_nonce;
  logic                  resp_valid, resp_ready, resp_grant;
  logic [1:0]            resp_reason;
  logic [31:0]           resp_hash, nonce_val;
  logic [DENY_CNT_W-1:0] deny_cnt;
  logic [1:0]            dbg_state;

  boreal_gate_enforcer #(.TGT_W(TGT_W), .DENY_CNT_W(DENY_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .allow0(allow0), .allow1(allow1),
    .rate_limit(rate_limit), .rate_window(rate_window), .policy_hash(policy_hash),
    .override_reg(override_reg), .override_lock(override_lock),
    .req_valid(req_valid), .req_ready(req_ready), .req_target(req_target),
    .req_nonce(req_nonce), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_grant(resp_grant), .resp_reason(resp_reason), .resp_hash(resp_hash),
    .nonce_val(nonce_val), .deny_cnt(deny_cnt), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Values captured by do_req during the RESP cycle
  logic        o_grant;
  logic [1:0]  o_reason;
  logic [31:0] o_hash;
  logic        lat_err;

  // Driver: issue one request; resp_valid must be 0 after the accept edge
  // and 1 after the following edge. Leaves RESP only if resp_ready is 1.
  task automatic do_req(input logic [TGT_W-1:0] tgt, input logic [31:0] nonce);
    int n = 0;
    lat_err = 1'b0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (req_ready !== 1'b1) lat_err = 1'b1;
    req_valid  = 1'b1;
    req_target = tgt;
    req_nonce  = nonce;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0) lat_err = 1'b1;
    @(posedge clk); #1;
    if (resp_valid !== 1'b1) lat_err = 1'b1;
    o_grant  = resp_grant;
    o_reason = resp_reason;
    o_hash   = resp_hash;
    if (resp_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b exp 1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b exp 0", resp_valid); end
    n_checks++; if (nonce_val !== 32'd0) begin n_fail++; $display("FAIL rst_nonce: got %h exp 0", nonce_val); end
    n_checks++; if (deny_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_deny: got %h exp 0", deny_cnt); end
    n_checks++; if ({resp_grant, resp_reason, resp_hash} !== 35'd0) begin n_fail++; $display("FAIL rst_verdict: got %b/%0d/%h exp 0/0/0", resp_grant, resp_reason, resp_hash); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d exp 0", dbg_state); end
  endtask

  task automatic test_grant();
    do_req(6'd0, 32'd0);
    n_checks++; if (lat_err !== 1'b0) begin n_fail++; $display("FAIL grant_latency: got err %b exp 0", lat_err); end
    n_checks++; if (o_grant !== 1'b1 || o_reason !== 2'd0) begin n_fail++; $display("FAIL grant_verdict: got %b/%0d exp 1/0", o_grant, o_reason); end
    n_checks++; if (o_hash !== 32'hB0E1_0001) begin n_fail++; $display("FAIL grant_hash: got %h exp b0e10001", o_hash); end
    n_checks++; if (nonce_val !== 32'd1) begin n_fail++; $display("FAIL grant_nonce: got %h exp 1", nonce_val); end
  endtask

  task automatic test_nonce();
    do_req(6'd0, 32'd5);
    n_checks++; if (o_grant !== 1'b0 || o_reason !== 2'd1) begin n_fail++; $display("FAIL stale_nonce: got %b/%0d exp 0/1", o_grant, o_reason); end
    n_checks++; if (nonce_val !== 32'd1) begin n_fail++; $display("FAIL stale_nonce_val: got %h exp 1", nonce_val); end
    n_checks++; if (deny_cnt !== 16'd1) begin n_fail++; $display("FAIL stale_deny: got %0d exp 1", deny_cnt); end
    override_reg = 32'h3;
    do_req(6'd0, 32'd5);
    n_checks++; if (o_reason !== 2'd1) begin n_fail++; $display("FAIL stale_ovr: got %0d exp 1", o_reason); end
    n_checks++; if (deny_cnt !== 16'd2) begin n_fail++; $display("FAIL stale_ovr_deny: got %0d exp 2", deny_cnt); end
    override_reg = 32'h0;
  endtask

  task automatic test_target();
    allow1 = 32'h0;
    policy_hash = 32'hB0E1_0002;
    do_req(6'd40, 32'd1);
    n_checks++; if (o_grant !== 1'b0 || o_reason !== 2'd2) begin n_fail++; $display("FAIL tgt40_deny: got %b/%0d exp 0/2", o_grant, o_reason); end
    n_checks++; if (o_hash !== 32'hB0E1_0002) begin n_fail++; $display("FAIL tgt40_hash: got %h exp b0e10002", o_hash); end
    override_reg = 32'h1;
    do_req(6'd40, 32'd1);
    n_checks++; if (o_grant !== 1'b1 || o_reason !== 2'd0) begin n_fail++; $display("FAIL tgt40_ovr: got %b/%0d exp 1/0", o_grant, o_reason); end
    n_checks++; if (nonce_val !== 32'd2) begin n_fail++; $display("FAIL tgt40_ovr_nonce: got %h exp 2", nonce_val); end
    override_lock = 1'b1;
    do_req(6'd40, 32'd2);
    n_checks++; if (o_reason !== 2'd2) begin n_fail++; $display("FAIL tgt40_lock: got %0d exp 2", o_reason); end
    n_checks++; if (deny_cnt !== 16'd4) begin n_fail++; $display("FAIL tgt40_lock_deny: got %0d exp 4", deny_cnt); end
    override_reg  = 32'h0;
    override_lock = 1'b0;
    allow1 = 32'h2;
    do_req(6'd33, 32'd2);
    n_checks++; if (o_reason !== 2'd0) begin n_fail++; $display("FAIL tgt33_allow1: got %0d exp 0", o_reason); end
    do_req(6'd32, 32'd3);
    n_checks++; if (o_reason !== 2'd2) begin n_fail++; $display("FAIL tgt32_allow1: got %0d exp 2", o_reason); end
    allow0 = 32'h8000_0001;
    do_req(6'd31, 32'd3);
    n_checks++; if (o_reason !== 2'd0) begin n_fail++; $display("FAIL tgt31_allow0: got %0d exp 0", o_reason); end
    n_checks++; if (nonce_val !== 32'd4 || deny_cnt !== 16'd5) begin n_fail++; $display("FAIL tgt_counters: got %h/%0d exp 4/5", nonce_val, deny_cnt); end
    allow0 = 32'h1;
  endtask

  task automatic test_back_to_back_rate();
    rate_limit  = 32'd2;
    rate_window = 32'd100;
    apply_reset();
    do_req(6'd0, 32'd0);
    n_checks++; if (o_reason !== 2'd0 || lat_err !== 1'b0) begin n_fail++; $display("FAIL rate_first: got %0d/%b exp 0/0", o_reason, lat_err); end
    do_req(6'd0, 32'd1);
    n_checks++; if (o_reason !== 2'd0 || lat_err !== 1'b0) begin n_fail++; $display("FAIL rate_second: got %0d/%b exp 0/0", o_reason, lat_err); end
    do_req(6'd0, 32'd2);
    n_checks++; if (o_grant !== 1'b0 || o_reason !== 2'd3) begin n_fail++; $display("FAIL rate_third: got %b/%0d exp 0/3", o_grant, o_reason); end
    override_reg = 32'h2;
    do_req(6'd0, 32'd2);
    n_checks++; if (o_reason !== 2'd0) begin n_fail++; $display("FAIL rate_bypass: got %0d exp 0", o_reason); end
    override_reg = 32'h0;
    rate_limit = 32'd0;
    do_req(6'd0, 32'd3);
    n_checks++; if (o_reason !== 2'd3) begin n_fail++; $display("FAIL rate_zero_limit: got %0d exp 3", o_reason); end
    rate_limit = 32'd2;
    repeat (100) @(posedge clk);
    #1;
    do_req(6'd0, 32'd3);
    n_checks++; if (o_reason !== 2'd0) begin n_fail++; $display("FAIL rate_after_roll: got %0d exp 0", o_reason); end
    n_checks++; if (nonce_val !== 32'd4 || deny_cnt !== 16'd2) begin n_fail++; $display("FAIL rate_counters: got %h/%0d exp 4/2", nonce_val, deny_cnt); end
  endtask

  task automatic test_rollover_grant();
    // Window of 5 after reset rolls on the 5th edge; the verdict edge of a
    // request driven after the 3rd edge lands exactly on it.
    rate_window = 32'd5;
    rate_limit  = 32'd1;
    apply_reset();
    repeat (3) @(posedge clk);
    #1;
    do_req(6'd0, 32'd0);
    n_checks++; if (o_reason !== 2'd0) begin n_fail++; $display("FAIL roll_edge_grant: got %0d exp 0", o_reason); end
    do_req(6'd0, 32'd1);
    n_checks++; if (o_reason !== 2'd3) begin n_fail++; $display("FAIL roll_commit_one: got %0d exp 3", o_reason); end
  endtask

  task automatic test_zero_window();
    rate_window = 32'd0;
    rate_limit  = 32'd1;
    for (int i = 0; i < 3; i++) begin
      do_req(6'd0, 32'(i + 1));
      n_checks++; if (o_reason !== 2'd0) begin n_fail++; $display("FAIL zero_window_%0d: got %0d exp 0", i, o_reason); end
    end
    n_checks++; if (nonce_val !== 32'd4 || deny_cnt !== 16'd1) begin n_fail++; $display("FAIL zero_window_cnt: got %h/%0d exp 4/1", nonce_val, deny_cnt); end
  endtask

  task automatic test_backpressure();
    rate_limit  = 32'd10;
    rate_window = 32'd1000;
    policy_hash = 32'hB0E1_0003;
    resp_ready  = 1'b0;
    do_req(6'd0, 32'd4);
    n_checks++; if (o_grant !== 1'b1 || o_hash !== 32'hB0E1_0003) begin n_fail++; $display("FAIL bp_verdict: got %b/%h exp 1/b0e10003", o_grant, o_hash); end
    for (int i = 0; i < 20; i++) begin
      policy_hash = 32'hDEAD_0000 + 32'(i);
      allow0      = 32'(i);
      @(posedge clk); #1;
      n_checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_%0d: got valid %b ready %b exp 1/0", i, resp_valid, req_ready); end
      n_checks++; if (resp_grant !== 1'b1 || resp_reason !== 2'd0 || resp_hash !== 32'hB0E1_0003) begin n_fail++; $display("FAIL bp_stable_%0d: got %b/%0d/%h exp 1/0/b0e10003", i, resp_grant, resp_reason, resp_hash); end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL bp_release: got ready %b valid %b state %0d exp 1/0/0", req_ready, resp_valid, dbg_state); end
    n_checks++; if (nonce_val !== 32'd5) begin n_fail++; $display("FAIL bp_nonce: got %h exp 5", nonce_val); end
    allow0      = 32'h1;
    policy_hash = 32'hB0E1_0001;
  endtask

  task automatic test_nonce_wrap();
    force dut.nonce_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.nonce_q;
    n_checks++; if (nonce_val !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload: got %h exp ffffffff", nonce_val); end
    do_req(6'd0, 32'hFFFF_FFFF);
    n_checks++; if (o_reason !== 2'd0) begin n_fail++; $display("FAIL wrap_grant: got %0d exp 0", o_reason); end
    n_checks++; if (nonce_val !== 32'd0) begin n_fail++; $display("FAIL wrap_nonce: got %h exp 0", nonce_val); end
  endtask

  task automatic test_reset_mid();
    req_valid  = 1'b1;
    req_target = 6'd0;
    req_nonce  = 32'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++; if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL mid_in_check: got %0d exp 1", dbg_state); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_checks++; if (nonce_val !== 32'd0 || deny_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_counters: got %h/%0d exp 0/0", nonce_val, deny_cnt); end
    n_checks++; if ({resp_grant, resp_reason, resp_hash} !== 35'd0) begin n_fail++; $display("FAIL mid_verdict: got %b/%0d/%h exp 0/0/0", resp_grant, resp_reason, resp_hash); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_no_resp_%0d: got valid %b ready %b exp 0/1", i, resp_valid, req_ready); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    allow0        = 32'h1;
    allow1        = 32'h0;
    rate_limit    = 32'd10;
    rate_window   = 32'd1000;
    policy_hash   = 32'hB0E1_0001;
    override_reg  = 32'h0;
    override_lock = 1'b0;
    req_valid     = 1'b0;
    req_target    = '0;
    req_nonce     = 32'd0;
    resp_ready    = 1'b1;
    rst_n         = 1'b0;
    test_reset();
    test_grant();
    test_nonce();
    test_target();
    test_back_to_back_rate();
    test_rollover_grant();
    test_zero_window();
    test_backpressure();
    test_nonce_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
